// File: rtl/fetch_queue.sv
// Instruction fetch queue.
// Issues sequential fetch requests from a local fetch PC, tags each accepted
// request with its PC in a small in-flight FIFO, and pairs in-order memory
// responses with those PCs into an instruction queue read by decode.
// A redirect flushes the queue and turns every in-flight request into a
// "drop" so its response is discarded when it eventually returns.
module fetch_queue #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                         iClk,
    input  logic                         iRstN,
    output logic                         oMemReqValid,
    output logic [ADDR_WIDTH-1:0]        oMemAddr,
    input  logic                         iMemReqReady,
    input  logic                         iMemRspValid,
    input  logic [DATA_WIDTH-1:0]        iMemRspData,
    input  logic                         iRedirect,
    input  logic [ADDR_WIDTH-1:0]        iRedirectPC,
    output logic                         oInstrValid,
    output logic [DATA_WIDTH-1:0]        oInstr,
    output logic [ADDR_WIDTH-1:0]        oInstrPC,
    input  logic                         iInstrReady,
    output logic [$clog2(DEPTH+1)-1:0]   oCount
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int IF_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    // wide enough to hold queue occupancy plus every in-flight request
    localparam int SUM_W = $clog2(DEPTH + MAX_OUTSTANDING + 1) + 1;

    logic [ADDR_WIDTH-1:0] fpc;

    logic [DATA_WIDTH-1:0] q_data [DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc   [DEPTH];
    logic [PTR_W-1:0]      q_wptr;
    logic [PTR_W-1:0]      q_rptr;
    logic [CNT_W-1:0]      q_count;

    logic [ADDR_WIDTH-1:0] if_pc [MAX_OUTSTANDING];
    logic [IF_W-1:0]       if_wptr;
    logic [IF_W-1:0]       if_rptr;
    logic [IF_W-1:0]       if_wptr_nxt;
    logic [IF_W-1:0]       if_rptr_nxt;

    // outstanding counts every in-flight request; drop_cnt is the subset
    // whose responses will be thrown away
    logic [OUT_W-1:0]      outstanding;
    logic [OUT_W-1:0]      drop_cnt;

    logic [SUM_W-1:0]      credits_used;
    logic                  req_fire;
    logic                  rsp_fire;
    logic                  rsp_drop;
    logic                  q_push;
    logic                  q_pop;

    // request gating, handshake decode and head-of-queue outputs
    always_comb begin
        // queued entries plus live requests reserve queue slots, so a
        // response can never find the queue full
        credits_used = SUM_W'(q_count) + SUM_W'(outstanding) - SUM_W'(drop_cnt);
        oMemReqValid = iRstN && !iRedirect
                       && (credits_used < SUM_W'(DEPTH))
                       && (SUM_W'(outstanding) < SUM_W'(MAX_OUTSTANDING));
        oMemAddr     = fpc;

        req_fire = oMemReqValid && iMemReqReady;
        rsp_fire = iMemRspValid && (outstanding != '0);
        rsp_drop = (drop_cnt != '0) || iRedirect;
        q_push   = rsp_fire && !rsp_drop;
        q_pop    = oInstrValid && iInstrReady && !iRedirect;

        if_wptr_nxt = (if_wptr == IF_W'(MAX_OUTSTANDING - 1)) ? '0 : if_wptr + IF_W'(1);
        if_rptr_nxt = (if_rptr == IF_W'(MAX_OUTSTANDING - 1)) ? '0 : if_rptr + IF_W'(1);

        oInstrValid = (q_count != '0);
        oInstr      = q_data[q_rptr];
        oInstrPC    = q_pc[q_rptr];
        oCount      = q_count;
    end

    // storage arrays; validity is tracked by the pointers, so no reset here
    always_ff @(posedge iClk) begin
        if (iRstN && req_fire) begin
            if_pc[if_wptr] <= fpc;
        end
        if (iRstN && q_push) begin
            q_data[q_wptr] <= iMemRspData;
            q_pc[q_wptr]   <= if_pc[if_rptr];
        end
    end

    // fetch PC, in-flight bookkeeping, drop accounting and queue pointers
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            fpc         <= RESET_PC;
            if_wptr     <= '0;
            if_rptr     <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            q_wptr      <= '0;
            q_rptr      <= '0;
            q_count     <= '0;
        end else begin
            if (req_fire) begin
                if_wptr <= if_wptr_nxt;
            end
            if (rsp_fire) begin
                if_rptr <= if_rptr_nxt;
            end
            outstanding <= outstanding + OUT_W'(req_fire) - OUT_W'(rsp_fire);

            if (iRedirect) begin
                fpc      <= {iRedirectPC[ADDR_WIDTH-1:2], 2'b00};
                // everything still in flight after this edge is stale,
                // whether it was already being dropped or not
                drop_cnt <= outstanding - OUT_W'(rsp_fire);
                q_wptr   <= '0;
                q_rptr   <= '0;
                q_count  <= '0;
            end else begin
                if (req_fire) begin
                    fpc <= fpc + ADDR_WIDTH'(4);
                end
                if (rsp_fire && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - OUT_W'(1);
                end
                if (q_push) begin
                    q_wptr <= q_wptr + PTR_W'(1);
                end
                if (q_pop) begin
                    q_rptr <= q_rptr + PTR_W'(1);
                end
                q_count <= q_count + CNT_W'(q_push) - CNT_W'(q_pop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: a table of per-cycle vectors, hand sequences for
// redirect/wrap/reset corners, and a random phase, all backed by a scoreboard
// that tracks in-flight requests and expected queue contents.
module tb_fetch_queue;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int MO    = 2;
    localparam logic [31:0] RST_PC = 32'h0;

    logic          iClk = 1'b0;
    logic          iRstN;
    logic          oMemReqValid;
    logic [AW-1:0] oMemAddr;
    logic          iMemReqReady;
    logic          iMemRspValid;
    logic [DW-1:0] iMemRspData;
    logic          iRedirect;
    logic [AW-1:0] iRedirectPC;
    logic          oInstrValid;
    logic [DW-1:0] oInstr;
    logic [AW-1:0] oInstrPC;
    logic          iInstrReady;
    logic [2:0]    oCount;

    always #5 iClk = ~iClk;

    fetch_queue #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .MAX_OUTSTANDING(MO), .RESET_PC(RST_PC)
    ) dut (
        .iClk(iClk), .iRstN(iRstN),
        .oMemReqValid(oMemReqValid), .oMemAddr(oMemAddr), .iMemReqReady(iMemReqReady),
        .iMemRspValid(iMemRspValid), .iMemRspData(iMemRspData),
        .iRedirect(iRedirect), .iRedirectPC(iRedirectPC),
        .oInstrValid(oInstrValid), .oInstr(oInstr), .oInstrPC(oInstrPC),
        .iInstrReady(iInstrReady), .oCount(oCount)
    );

    int errors = 0;
    int checks = 0;

    bit          k_rst_n, k_mem_ready, k_dec_ready, k_rsp_en, k_redirect, k_spurious;
    logic [31:0] k_redirect_pc;

    logic [31:0] m_fpc;
    bit          m_rv;
    logic [31:0] infl_addr_q[$];
    bit          infl_stale_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] drained_q[$];

    typedef struct {
        bit          rst_n;
        bit          mem_ready;
        bit          dec_ready;
        bit          redirect;
        logic [31:0] rpc;
        bit          exp_rv;
        logic [31:0] exp_addr;
        int          exp_cnt;
    } vec_t;
    vec_t vecs[11];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // drive inputs for this cycle and compare outputs against the model
    task automatic apply();
        int live;
        iRstN        = k_rst_n;
        iMemReqReady = k_mem_ready;
        iInstrReady  = k_dec_ready;
        iRedirect    = k_redirect;
        iRedirectPC  = k_redirect_pc;
        if (k_rst_n && k_rsp_en && infl_addr_q.size() != 0) begin
            iMemRspValid = 1'b1;
            iMemRspData  = mem_data(infl_addr_q[0]);
        end else if (k_spurious && infl_addr_q.size() == 0) begin
            iMemRspValid = 1'b1;
            iMemRspData  = 32'hDEAD_BEEF;
        end else begin
            iMemRspValid = 1'b0;
            iMemRspData  = '0;
        end
        #1;
        live = 0;
        for (int i = 0; i < infl_stale_q.size(); i++) if (!infl_stale_q[i]) live++;
        m_rv = k_rst_n && !k_redirect && (exp_pc_q.size() + live < DEPTH) && (infl_addr_q.size() < MO);
        check("mem_req_valid", oMemReqValid, m_rv);
        if (oMemReqValid) check("mem_addr", oMemAddr, m_fpc);
        check("count", oCount, exp_pc_q.size());
        check("instr_valid", oInstrValid, exp_pc_q.size() != 0);
        if (oInstrValid && exp_pc_q.size() != 0) begin
            check("instr_pc", oInstrPC, exp_pc_q[0]);
            check("instr_data", oInstr, exp_data_q[0]);
        end
    endtask

    // update the model with this cycle's handshakes, then step one clock
    task automatic advance();
        logic [31:0] a;
        bit          s;
        if (!k_rst_n) begin
            infl_addr_q.delete();
            infl_stale_q.delete();
            exp_pc_q.delete();
            exp_data_q.delete();
            m_fpc = RST_PC;
        end else begin
            if (exp_pc_q.size() != 0 && k_dec_ready && !k_redirect) begin
                drained_q.push_back(exp_pc_q.pop_front());
                void'(exp_data_q.pop_front());
            end
            if (iMemRspValid && infl_addr_q.size() != 0) begin
                a = infl_addr_q.pop_front();
                s = infl_stale_q.pop_front();
                if (!s && !k_redirect) begin
                    exp_pc_q.push_back(a);
                    exp_data_q.push_back(mem_data(a));
                end
            end
            if (m_rv && k_mem_ready) begin
                infl_addr_q.push_back(m_fpc);
                infl_stale_q.push_back(1'b0);
                m_fpc = m_fpc + 32'd4;
            end
            if (k_redirect) begin
                exp_pc_q.delete();
                exp_data_q.delete();
                for (int i = 0; i < infl_stale_q.size(); i++) infl_stale_q[i] = 1'b1;
                m_fpc = k_redirect_pc & ~32'h3;
            end
        end
        @(posedge iClk);
        @(negedge iClk);
    endtask

    task automatic cycle();
        apply();
        advance();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        bit found;

        // rst, mem_rdy, dec_rdy, redirect, rpc, exp_req_valid, exp_addr, exp_count
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00, 0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h04, 0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h08, 1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0C, 2};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h00, 3};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h00, 4};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h00, 4};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h00, 4};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 3};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h14, 2};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h18, 2};

        k_rst_n = 0; k_mem_ready = 1; k_dec_ready = 1; k_rsp_en = 1;
        k_redirect = 0; k_spurious = 0; k_redirect_pc = '0;
        iRstN = 0; iMemReqReady = 0; iMemRspValid = 0; iMemRspData = '0;
        iRedirect = 0; iRedirectPC = '0; iInstrReady = 0;
        m_fpc = RST_PC; m_rv = 0;

        repeat (2) @(posedge iClk);
        @(negedge iClk);
        check("rst_count", oCount, 0);
        check("rst_instr_valid", oInstrValid, 0);
        check("rst_req_valid", oMemReqValid, 0);

        // fill to saturation with decode stalled, then drain
        for (int i = 0; i < 11; i++) begin
            k_rst_n = vecs[i].rst_n; k_mem_ready = vecs[i].mem_ready;
            k_dec_ready = vecs[i].dec_ready; k_redirect = vecs[i].redirect;
            k_redirect_pc = vecs[i].rpc;
            apply();
            check("vec_req_valid", oMemReqValid, vecs[i].exp_rv);
            if (vecs[i].exp_rv) check("vec_addr", oMemAddr, vecs[i].exp_addr);
            check("vec_count", oCount, vecs[i].exp_cnt);
            advance();
        end
        run(8);

        // back-to-back fetch from reset with everything ready
        k_rst_n = 0; run(2); k_rst_n = 1;
        drained_q.delete();
        run(10);
        check("b2b_drain_len_ge3", drained_q.size() >= 3, 1);
        if (drained_q.size() >= 3) begin
            check("b2b_pc0", drained_q[0], 32'h0);
            check("b2b_pc1", drained_q[1], 32'h4);
            check("b2b_pc2", drained_q[2], 32'h8);
        end

        // two in flight at 0x10/0x14, then redirect to 0x103
        k_mem_ready = 0; run(6);
        k_redirect = 1; k_redirect_pc = 32'h10; cycle(); k_redirect = 0;
        k_rsp_en = 0; k_mem_ready = 1;
        run(2);
        apply(); check("r040_stall_two_inflight", oMemReqValid, 0); advance();
        k_redirect = 1; k_redirect_pc = 32'h103; cycle(); k_redirect = 0;
        k_rsp_en = 1;
        apply(); check("r040_count_cleared", oCount, 0); advance();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            apply();
            if (oMemReqValid) begin
                found = 1;
                check("r040_first_addr", oMemAddr, 32'h100);
            end
            advance();
        end
        check("r040_req_seen", found, 1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            apply();
            if (oInstrValid) begin
                found = 1;
                check("r040_first_pc", oInstrPC, 32'h100);
            end
            advance();
        end
        check("r040_instr_seen", found, 1);

        // redirect coinciding with a pop and a response
        run(6);
        k_redirect = 1; k_redirect_pc = 32'h200;
        apply();
        check("r041_setup_pop", oInstrValid, 1);
        check("r041_setup_rsp", iMemRspValid, 1);
        advance();
        k_redirect = 0;
        apply(); check("r041_count_cleared", oCount, 0); advance();
        run(6);

        // fetch PC wraps at the top of the address space
        k_redirect = 1; k_redirect_pc = 32'hFFFF_FFFE; cycle(); k_redirect = 0;
        apply();
        check("wrap_valid0", oMemReqValid, 1);
        check("wrap_addr0", oMemAddr, 32'hFFFF_FFFC);
        advance();
        apply();
        check("wrap_valid1", oMemReqValid, 1);
        check("wrap_addr1", oMemAddr, 32'h0);
        advance();
        run(6);

        // response with nothing outstanding is ignored
        k_mem_ready = 0; run(6);
        k_spurious = 1; cycle(); k_spurious = 0;
        apply(); check("spurious_count", oCount, 0); advance();
        k_mem_ready = 1;

        // random traffic
        for (int i = 0; i < 200; i++) begin
            k_mem_ready   = ($urandom_range(0, 3) != 0);
            k_dec_ready   = ($urandom_range(0, 2) != 0);
            k_rsp_en      = ($urandom_range(0, 2) != 0);
            k_redirect    = ($urandom_range(0, 15) == 0);
            k_redirect_pc = $urandom;
            cycle();
        end
        k_redirect = 0; k_rsp_en = 1; k_mem_ready = 1; k_dec_ready = 1;
        run(8);

        // reset mid-stream with three entries queued
        k_rst_n = 0; run(2); k_rst_n = 1;
        k_dec_ready = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            apply();
            if (oCount == 3) found = 1;
            else advance();
        end
        check("r043_reached_3", found, 1);
        k_rst_n = 0;
        apply();
        advance();
        apply();
        check("r043_count", oCount, 0);
        check("r043_instr_valid", oInstrValid, 0);
        check("r043_req_valid", oMemReqValid, 0);
        advance();
        k_rst_n = 1; k_dec_ready = 1;
        apply();
        check("r043_release_valid", oMemReqValid, 1);
        check("r043_release_addr", oMemAddr, RST_PC);
        advance();
        run(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
